// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter in front of one slave port.
// Ownership is held for a whole wb_cyc frame; a watchdog errors out unanswered strobes.
module wb_arbiter_2m #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,

  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [aw-1:0] m0_adr_i,
  input  logic [dw-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  output logic [dw-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,

  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [aw-1:0] m1_adr_i,
  input  logic [dw-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  output logic [dw-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,

  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [aw-1:0] s_adr_o,
  output logic [dw-1:0] s_dat_o,
  output logic [3:0]    s_sel_o,
  input  logic [dw-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i,

  output logic [1:0]    grant_o,
  output logic          timeout_o
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LIMIT = CW'(LIM);

  state_t        state_q, state_d;
  logic          prio_q, prio_d;    // 0 favours m0, 1 favours m1
  logic [CW-1:0] cnt_q, cnt_d;

  logic own0, own1, act0, act1, term, wd_fire;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset clears state, which gates all outputs at once.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = prio_q ? OWN1 : OWN0;
        else if (m0_cyc_i)        state_d = OWN0;
        else if (m1_cyc_i)        state_d = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          state_d = IDLE;
          prio_d  = 1'b1;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          state_d = IDLE;
          prio_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Routing: an owner that drops cyc is cut off in the same cycle, so late
  // slave terminations never reach it.
  always_comb begin
    own0 = (state_q == OWN0);
    own1 = (state_q == OWN1);
    act0 = own0 && m0_cyc_i;
    act1 = own1 && m1_cyc_i;

    s_cyc_o = act0 || act1;
    s_stb_o = (act0 && m0_stb_i) || (act1 && m1_stb_i);
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (own0) begin
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (own1) begin
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end

    term    = s_ack_i || s_err_i || s_rty_i;
    // A real termination on the expiry cycle wins over the watchdog.
    wd_fire = (TIMEOUT != 0) && s_stb_o && !term && (cnt_q == LIMIT);

    m0_ack_o  = act0 && s_ack_i;
    m0_err_o  = act0 && (s_err_i || wd_fire);
    m0_rty_o  = act0 && s_rty_i;
    m1_ack_o  = act1 && s_ack_i;
    m1_err_o  = act1 && (s_err_i || wd_fire);
    m1_rty_o  = act1 && s_rty_i;
    m0_dat_o  = own0 ? s_dat_i : '0;
    m1_dat_o  = own1 ? s_dat_i : '0;
    grant_o   = state_q;
    timeout_o = wd_fire;
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if ((TIMEOUT == 0) || !s_stb_o || term || wd_fire) cnt_d = '0;
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: a per-cycle vector table plus hand sequences
// for round-robin streaming, watchdog expiry and reset during an owned strobe.
module tb_wb_arbiter_2m;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [31:0] m0_adr_i = 32'h4, m0_dat_i = 32'hAAAA_0000;
  logic [3:0]  m0_sel_i = 4'hF;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 1;
  logic [31:0] m1_adr_i = 32'h8, m1_dat_i = 32'h5555_0001;
  logic [3:0]  m1_sel_i = 4'h3;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i = '0;
  logic        s_ack_i = 0, s_err_i = 0, s_rty_i = 0;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  wb_arbiter_2m #(.dw(32), .aw(32), .TIMEOUT(16)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_dat_i = '0;
  endtask

  task automatic apply_reset();
    wb_rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge wb_clk);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
  endtask

  typedef struct {
    logic        c0, s0, c1, s1, ack;
    logic [31:0] dat;
    logic [1:0]  grant;
    logic        scyc, sstb, ack0, ack1;
    logic [31:0] dat0, dat1;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic c0, s0, c1, s1, ack, input logic [31:0] dat,
                              input logic [1:0] grant, input logic scyc, sstb, ack0, ack1,
                              input logic [31:0] dat0, dat1);
    vec_t v;
    v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack; v.dat = dat;
    v.grant = grant; v.scyc = scyc; v.sstb = sstb; v.ack0 = ack0; v.ack1 = ack1;
    v.dat0 = dat0; v.dat1 = dat1;
    return v;
  endfunction

  initial begin
    logic [1:0]  exp_g;
    logic [31:0] exp_adr, exp_wdat;
    int m0_frames, m1_frames, frames, budget;
    logic drop0, drop1;

    //                c0 s0 c1 s1 ak dat            grant scyc sstb a0 a1 dat0          dat1
    // both request out of reset: m0 first, idle gap, then m1
    vecs[0]  = mk(1, 1, 1, 1, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0,         32'h0);
    vecs[1]  = mk(1, 1, 1, 1, 1, 32'h11,         2'b01, 1, 1, 1, 0, 32'h11,        32'h0);
    vecs[2]  = mk(0, 0, 1, 1, 0, 32'h0,          2'b01, 0, 0, 0, 0, 32'h0,         32'h0);
    vecs[3]  = mk(0, 0, 1, 1, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0,         32'h0);
    vecs[4]  = mk(0, 0, 1, 1, 1, 32'h22,         2'b10, 1, 1, 0, 1, 32'h0,         32'h22);
    vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0,          2'b10, 0, 0, 0, 0, 32'h0,         32'h0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0,         32'h0);
    // m0 single read, acked one cycle after the grant
    vecs[7]  = mk(1, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0,         32'h0);
    vecs[8]  = mk(1, 1, 0, 0, 0, 32'h0,          2'b01, 1, 1, 0, 0, 32'h0,         32'h0);
    vecs[9]  = mk(1, 1, 0, 0, 1, 32'h0C0B000A,   2'b01, 1, 1, 1, 0, 32'h0C0B000A,  32'h0);
    vecs[10] = mk(0, 0, 0, 0, 0, 32'h0,          2'b01, 0, 0, 0, 0, 32'h0,         32'h0);
    vecs[11] = mk(0, 0, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0,         32'h0);
    // m0 holds cyc across 3 strobes while m1 waits; late ack on drop is discarded
    vecs[12] = mk(1, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0,         32'h0);
    vecs[13] = mk(1, 1, 1, 1, 1, 32'h0,          2'b01, 1, 1, 1, 0, 32'h0,         32'h0);
    vecs[14] = mk(1, 0, 1, 1, 0, 32'h0,          2'b01, 1, 0, 0, 0, 32'h0,         32'h0);
    vecs[15] = mk(1, 1, 1, 1, 1, 32'h0,          2'b01, 1, 1, 1, 0, 32'h0,         32'h0);
    vecs[16] = mk(1, 0, 1, 1, 0, 32'h0,          2'b01, 1, 0, 0, 0, 32'h0,         32'h0);
    vecs[17] = mk(1, 1, 1, 1, 1, 32'h0,          2'b01, 1, 1, 1, 0, 32'h0,         32'h0);
    vecs[18] = mk(0, 0, 1, 1, 1, 32'h0,          2'b01, 0, 0, 0, 0, 32'h0,         32'h0);
    vecs[19] = mk(0, 0, 1, 1, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0,         32'h0);
    vecs[20] = mk(0, 0, 1, 1, 1, 32'h33,         2'b10, 1, 1, 0, 1, 32'h0,         32'h33);
    vecs[21] = mk(0, 0, 0, 0, 0, 32'h0,          2'b10, 0, 0, 0, 0, 32'h0,         32'h0);
    vecs[22] = mk(0, 0, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 32'h0,         32'h0);

    // Reset state, checked while reset is still asserted.
    #2;
    check("rst_grant", grant_o, 2'b00);
    check("rst_s_cyc", s_cyc_o, 1'b0);
    check("rst_timeout", timeout_o, 1'b0);
    apply_reset();

    for (int i = 0; i < NV; i++) begin
      @(posedge wb_clk);
      #1;
      m0_cyc_i = vecs[i].c0; m0_stb_i = vecs[i].s0;
      m1_cyc_i = vecs[i].c1; m1_stb_i = vecs[i].s1;
      s_ack_i  = vecs[i].ack; s_dat_i = vecs[i].dat;
      @(negedge wb_clk);
      check($sformatf("v%0d_grant", i), grant_o, vecs[i].grant);
      check($sformatf("v%0d_s_cyc", i), s_cyc_o, vecs[i].scyc);
      check($sformatf("v%0d_s_stb", i), s_stb_o, vecs[i].sstb);
      check($sformatf("v%0d_m0_ack", i), m0_ack_o, vecs[i].ack0);
      check($sformatf("v%0d_m1_ack", i), m1_ack_o, vecs[i].ack1);
      check($sformatf("v%0d_m0_dat", i), m0_dat_o, vecs[i].dat0);
      check($sformatf("v%0d_m1_dat", i), m1_dat_o, vecs[i].dat1);
      exp_g    = vecs[i].grant;
      exp_adr  = (exp_g == 2'b01) ? 32'h4 : (exp_g == 2'b10) ? 32'h8 : 32'h0;
      exp_wdat = (exp_g == 2'b01) ? 32'hAAAA_0000 : (exp_g == 2'b10) ? 32'h5555_0001 : 32'h0;
      check($sformatf("v%0d_s_adr", i), s_adr_o, exp_adr);
      check($sformatf("v%0d_s_dat", i), s_dat_o, exp_wdat);
      check($sformatf("v%0d_s_we", i), s_we_o, exp_g == 2'b10);
    end

    // Continuous back-to-back frames from both masters: grants alternate.
    apply_reset();
    m0_frames = 0; m1_frames = 0; frames = 0; budget = 0;
    drop0 = 0; drop1 = 0;
    while (frames < 8 && budget < 100) begin
      @(posedge wb_clk);
      #1;
      m0_cyc_i = !drop0; m0_stb_i = !drop0;
      m1_cyc_i = !drop1; m1_stb_i = !drop1;
      s_ack_i  = 1'b1;
      @(negedge wb_clk);
      drop0 = m0_ack_o;
      drop1 = m1_ack_o;
      if (m0_ack_o || m1_ack_o) begin
        check($sformatf("rr_frame%0d_grant", frames), grant_o,
              (frames % 2 == 0) ? 2'b01 : 2'b10);
        check($sformatf("rr_frame%0d_single_ack", frames), m0_ack_o && m1_ack_o, 1'b0);
        if (m0_ack_o) m0_frames++;
        if (m1_ack_o) m1_frames++;
        frames++;
      end
      budget++;
    end
    check("rr_budget", budget < 100, 1'b1);
    check("rr_m0_frames", m0_frames, 4);
    check("rr_m1_frames", m1_frames, 4);

    // Watchdog: expiry on the 16th unanswered strobe cycle.
    apply_reset();
    @(posedge wb_clk);
    #1;
    m0_cyc_i = 1; m0_stb_i = 1;
    @(negedge wb_clk);
    check("wd_idle_grant", grant_o, 2'b00);
    for (int k = 1; k <= 17; k++) begin
      @(posedge wb_clk);
      @(negedge wb_clk);
      check($sformatf("wd_cyc%0d_err", k), m0_err_o, k == 16);
      check($sformatf("wd_cyc%0d_timeout", k), timeout_o, k == 16);
      check($sformatf("wd_cyc%0d_m1_err", k), m1_err_o, 1'b0);
    end
    @(posedge wb_clk);
    #1;
    m0_cyc_i = 0; m0_stb_i = 0;
    @(posedge wb_clk);
    #1;
    m0_cyc_i = 1; m0_stb_i = 1;
    // Slave ack on the expiry cycle wins over the watchdog.
    for (int k = 1; k <= 16; k++) begin
      @(posedge wb_clk);
      #1;
      s_ack_i = (k == 16);
      @(negedge wb_clk);
      if (k == 16) begin
        check("wd_ack16_ack", m0_ack_o, 1'b1);
        check("wd_ack16_err", m0_err_o, 1'b0);
        check("wd_ack16_timeout", timeout_o, 1'b0);
      end else begin
        check($sformatf("wd_ack_cyc%0d_err", k), m0_err_o, 1'b0);
      end
    end

    // Reset during an m1-owned strobe.
    apply_reset();
    @(posedge wb_clk);
    #1;
    m1_cyc_i = 1; m1_stb_i = 1;
    @(posedge wb_clk);
    @(negedge wb_clk);
    check("rstmid_pre_grant", grant_o, 2'b10);
    check("rstmid_pre_s_cyc", s_cyc_o, 1'b1);
    #2;
    s_ack_i  = 1'b1;
    wb_rst_n = 1'b0;
    #1;
    check("rstmid_s_cyc", s_cyc_o, 1'b0);
    check("rstmid_grant", grant_o, 2'b00);
    check("rstmid_m1_ack", m1_ack_o, 1'b0);
    check("rstmid_m0_ack", m0_ack_o, 1'b0);
    @(negedge wb_clk);
    s_ack_i  = 1'b0;
    m0_cyc_i = 1; m0_stb_i = 1;
    wb_rst_n = 1'b1;
    @(posedge wb_clk);
    @(negedge wb_clk);
    check("rstmid_after_grant", grant_o, 2'b01);

    clear_inputs();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
